// File: rtl/mul_seq_controller.sv
// ============================================================================
// mul_seq_controller : sequencing FSM for a shift/add (or radix-2 Booth) multiplier datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mul_seq_controller #(
  parameter int WIDTH     = 16,
  parameter int SIGNED    = 1,
  parameter int EARLY_OUT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic eqzM,
  input  logic eqzQ,
  input  logic q0,
  input  logic qm1,
  output logic ldM,
  output logic ldQ,
  output logic clrA,
  output logic ldA,
  output logic addsub,
  output logic shift,
  output logic clrP,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADM = 3'd1,
    S_LOADQ = 3'd2,
    S_CHECK = 3'd3,
    S_EVAL  = 3'd4,
    S_SHIFT = 3'd5,
    S_ZERO  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ldM       = 1'b0;
    ldQ       = 1'b0;
    clrA      = 1'b0;
    ldA       = 1'b0;
    addsub    = 1'b0;
    shift     = 1'b0;
    clrP      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOADM;
      end
      S_LOADM: begin
        busy      = 1'b1;
        ldM       = 1'b1;
        state_nxt = S_LOADQ;
      end
      S_LOADQ: begin
        busy      = 1'b1;
        ldQ       = 1'b1;
        clrA      = 1'b1;
        cnt_nxt   = CNT_LOAD;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if ((EARLY_OUT != 0) && (eqzM || eqzQ)) state_nxt = S_ZERO;
        else                                    state_nxt = S_EVAL;
      end
      S_EVAL: begin
        busy      = 1'b1;
        state_nxt = S_SHIFT;
        // Booth pair 10 subtracts, 01 adds; unsigned mode adds on q0 alone.
        if (SIGNED != 0) begin
          if (q0 && !qm1) begin
            ldA    = 1'b1;
            addsub = 1'b1;
          end else if (!q0 && qm1) begin
            ldA    = 1'b1;
          end
        end else if (q0) begin
          ldA = 1'b1;
        end
      end
      S_SHIFT: begin
        busy    = 1'b1;
        shift   = 1'b1;
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = S_DONE;
        else                state_nxt = S_EVAL;
      end
      S_ZERO: begin
        busy      = 1'b1;
        clrP      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_LOADM;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
